// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between NREQ requesters, with a one-entry
// valid/ready response register. Optional per-requester perf counters under ALU_ARB_PERF_EN.
module alu_share_arbiter #(
  parameter int          NREQ          = 2,
  parameter int          IDW           = 1,
  parameter int          CNTW          = 16,
  parameter logic [3:0]  ALU_NONE_CODE = 4'b0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [4*NREQ-1:0]    req_ctrl,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  output logic [3:0]           alu_ctrl,
  output logic [31:0]          alu_a,
  output logic [31:0]          alu_b,
  input  logic [31:0]          alu_out,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [31:0]          rsp_data
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [CNTW*NREQ-1:0] perf_grant,
  output logic [CNTW-1:0]      perf_stall
`endif
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high.
  // Requesters hold ctrl/a/b while valid && !ready; the response holds while rsp_valid && !rsp_ready.
  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [31:0]     rsp_data_q, rsp_data_d;

  logic            can_accept;
  logic            found;
  logic            grant;
  logic [IDW-1:0]  gnt_idx;

  assign can_accept = (state_q == ST_EMPTY) || rsp_ready;

  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (int'(rr_ptr_q) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found   = 1'b1;
        gnt_idx = IDW'(idx);
      end
    end
  end

  // Reset blocks grants so nothing is accepted during the reset cycle.
  assign grant     = found && can_accept && !rst;
  assign req_ready = grant ? (NREQ'(1) << gnt_idx) : '0;

  always_comb begin
    alu_ctrl = ALU_NONE_CODE;
    alu_a    = '0;
    alu_b    = '0;
    if (grant) begin
      alu_ctrl = req_ctrl[4*gnt_idx +: 4];
      alu_a    = req_a[32*gnt_idx +: 32];
      alu_b    = req_b[32*gnt_idx +: 32];
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    rsp_id_d   = rsp_id_q;
    rsp_data_d = rsp_data_q;
    if (grant) begin
      state_d    = ST_FULL;
      rr_ptr_d   = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
      rsp_id_d   = gnt_idx;
      rsp_data_d = alu_out;
    end else if (state_q == ST_FULL && rsp_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      rr_ptr_q   <= '0;
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      rsp_id_q   <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign rsp_valid = (state_q == ST_FULL);
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;

`ifdef ALU_ARB_PERF_EN
  logic [NREQ-1:0][CNTW-1:0] perf_grant_q, perf_grant_d;
  logic [CNTW-1:0]           perf_stall_q, perf_stall_d;

  // Counters saturate at all-ones instead of wrapping.
  always_comb begin
    perf_grant_d = perf_grant_q;
    perf_stall_d = perf_stall_q;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i] && perf_grant_q[i] != '1) perf_grant_d[i] = perf_grant_q[i] + 1'b1;
    end
    if (|req_valid && !grant && perf_stall_q != '1) perf_stall_d = perf_stall_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_grant_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_grant_q <= perf_grant_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_grant = perf_grant_q;
  assign perf_stall = perf_stall_q;
`endif

endmodule
